// File: rtl/cmd_stream_encoder_pkg.sv
// Shared constants and state encoding for the command stream encoder.
package cmd_stream_encoder_pkg;

    // Tag carried in bits [27:20] of every header word
    localparam logic [7:0] HDR_TAG    = 8'h64;

    // Header subtypes carried in bits [19:16]
    localparam logic [3:0] HDR_COUNT  = 4'h0;
    localparam logic [3:0] HDR_OUTCNT = 4'h1;
    localparam logic [3:0] HDR_SIZE   = 4'h2;

    // Op type that produces one output word at the receiver
    localparam logic [3:0] OP_Y       = 4'h3;

    // FIFO entry width: {is_y, op_word, op_data}
    localparam int unsigned ENTRY_W   = 65;

    typedef enum logic [2:0] {
        StIdle,
        StSize,
        StOcnt,
        StCount,
        StOpw,
        StDatw
    } state_e;

endpackage

// File: rtl/cmd_stream_encoder_pair_fifo.sv
// Pair FIFO: DEPTH entries, combinational head, occupancy count.
module cmd_stream_encoder_pair_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned W     = 65
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   fcount
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fcount_q, fcount_d;
    logic          do_push, do_pop;

    assign full    = (fcount_q == (AW+1)'(DEPTH));
    assign empty   = (fcount_q == '0);
    assign fcount  = fcount_q;
    assign rdata   = mem_q[rd_ptr_q];

    // A push into a full FIFO is still taken if a pop frees a slot this cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Occupancy next-state
    always_comb begin
        fcount_d = fcount_q;
        case ({do_push, do_pop})
            2'b10:   fcount_d = fcount_q + 1'b1;
            2'b01:   fcount_d = fcount_q - 1'b1;
            default: fcount_d = fcount_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcount_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            fcount_q <= fcount_d;
        end
    end

    // Storage; contents are don't-care while empty so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/cmd_stream_encoder.sv
// Frames buffered (op, data) pairs into header-prefixed batches on one stream.
module cmd_stream_encoder
    import cmd_stream_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] op_word,
    input  logic [31:0] op_data,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        flush,
    input  logic [8:0]  size_cfg,
    input  logic        size_valid,
    output logic [31:0] stream_word,
    output logic        stream_valid,
    input  logic        stream_ready,
    output logic        busy
);

    state_e               state_q, state_d;
    logic [AW:0]          ycnt_q, ycnt_d;
    logic [AW:0]          n_q, y_q, remaining_q;
    logic [8:0]           size_reg_q, size_hdr_q;
    logic                 size_pend_q;
    logic [ENTRY_W-1:0]   head;
    logic                 full, empty;
    logic [AW:0]          fcount;
    logic                 push, pop, xfer, batch_go;

    assign op_ready = !full;
    assign push     = op_valid && op_ready;
    assign xfer     = stream_valid && stream_ready;
    assign pop      = (state_q == StDatw) && xfer;
    assign batch_go = (flush || full) && !empty;

    cmd_stream_encoder_pair_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_pair_fifo (
        .clk    (clk),
        .clear  (clear),
        .push   (push),
        .wdata  ({op_word[3:0] == OP_Y, op_word, op_data}),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .fcount (fcount)
    );

    // Count of output-producing ops currently held in the FIFO
    always_comb begin
        ycnt_d = ycnt_q;
        case ({push && (op_word[3:0] == OP_Y), pop && head[ENTRY_W-1]})
            2'b10:   ycnt_d = ycnt_q + 1'b1;
            2'b01:   ycnt_d = ycnt_q - 1'b1;
            default: ycnt_d = ycnt_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state: a pending size header wins over starting a batch
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (size_pend_q)   state_d = StSize;
                else if (batch_go) state_d = (ycnt_q != '0) ? StOcnt : StCount;
            end
            StSize:  if (xfer) state_d = StIdle;
            StOcnt:  if (xfer) state_d = StCount;
            StCount: if (xfer) state_d = StOpw;
            StOpw:   if (xfer) state_d = StDatw;
            StDatw:  if (xfer) state_d = (remaining_q == (AW+1)'(1)) ? StIdle : StOpw;
            default: state_d = StIdle;
        endcase
    end

    // Batch snapshot, remaining counter, size bookkeeping, output-count tracking
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ycnt_q      <= '0;
            n_q         <= '0;
            y_q         <= '0;
            remaining_q <= '0;
            size_reg_q  <= '0;
            size_hdr_q  <= '0;
            size_pend_q <= 1'b0;
        end else begin
            ycnt_q <= ycnt_d;
            if (state_q == StIdle && !size_pend_q && batch_go) begin
                n_q <= fcount;
                y_q <= ycnt_q;
            end
            if (state_q == StCount && xfer) remaining_q <= n_q;
            else if (pop)                   remaining_q <= remaining_q - 1'b1;
            // Freeze the presented size so a new strobe cannot alter a held word
            if (state_q == StIdle && size_pend_q) size_hdr_q <= size_reg_q;
            if (size_valid) begin
                size_reg_q  <= size_cfg;
                size_pend_q <= 1'b1;
            end else if (state_q == StSize && xfer) begin
                size_pend_q <= 1'b0;
            end
        end
    end

    // Outputs decoded from registered state and FIFO head; stable until a transfer
    always_comb begin
        stream_word  = '0;
        stream_valid = 1'b0;
        busy         = 1'b0;
        unique case (state_q)
            StIdle: ;
            StSize: begin
                stream_word  = {4'h0, HDR_TAG, HDR_SIZE, 7'b0, size_hdr_q};
                stream_valid = 1'b1;
            end
            StOcnt: begin
                stream_word  = {4'h0, HDR_TAG, HDR_OUTCNT, {(15 - AW){1'b0}}, y_q};
                stream_valid = 1'b1;
                busy         = 1'b1;
            end
            StCount: begin
                stream_word  = {4'h0, HDR_TAG, HDR_COUNT, {(15 - AW){1'b0}}, n_q};
                stream_valid = 1'b1;
                busy         = 1'b1;
            end
            StOpw: begin
                stream_word  = head[63:32];
                stream_valid = 1'b1;
                busy         = 1'b1;
            end
            StDatw: begin
                stream_word  = head[31:0];
                stream_valid = 1'b1;
                busy         = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cmd_stream_encoder.sv
// Directed bench with an expected-word scoreboard for cmd_stream_encoder.
module tb_cmd_stream_encoder;

    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] op_word, op_data;
    logic        op_valid, op_ready, flush;
    logic [8:0]  size_cfg;
    logic        size_valid;
    logic [31:0] stream_word;
    logic        stream_valid, stream_ready, busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic        held_v = 1'b0;
    logic [31:0] held_w = '0;

    cmd_stream_encoder dut (
        .clk          (clk),
        .clear        (clear),
        .op_word      (op_word),
        .op_data      (op_data),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .flush        (flush),
        .size_cfg     (size_cfg),
        .size_valid   (size_valid),
        .stream_word  (stream_word),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check at negedge, then return just after the next posedge
    task automatic tick();
        @(negedge clk);
        if (held_v) begin
            chk("hold_valid", {31'b0, stream_valid}, 32'd1);
            chk("hold_word", stream_word, held_w);
        end
        if (stream_valid && stream_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL extra_word observed=%h expected=none", stream_word);
            end else begin
                chk("stream_word", stream_word, exp_q.pop_front());
            end
        end
        held_v = stream_valid && !stream_ready;
        held_w = stream_word;
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] w, input logic [31:0] d);
        op_word  = w;
        op_data  = d;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain(input int budget, input bit toggle);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            if (toggle) stream_ready = ~stream_ready;
            tick();
            k++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
        exp_q.delete();
        stream_ready = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'b0, stream_valid}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'b0, op_ready}, 32'd1);
    endtask

    initial begin
        clear        = 1'b1;
        op_word      = '0;
        op_data      = '0;
        op_valid     = 1'b0;
        flush        = 1'b0;
        size_cfg     = '0;
        size_valid   = 1'b0;
        stream_ready = 1'b1;
        #12;
        chk_idle("reset");
        chk("reset_word", stream_word, 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;

        // Idle with no stimulus
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle("idle");
        end

        // Two pairs, one producing output, explicit flush
        push_pair(32'h1, 32'hA);
        push_pair(32'h3, 32'hB);
        exp_q.push_back(32'h0641_0001);
        exp_q.push_back(32'h0640_0002);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'hA);
        exp_q.push_back(32'h3);
        exp_q.push_back(32'hB);
        do_flush();
        chk("batch_busy", {31'b0, busy}, 32'd1);
        drain(40, 1'b0);
        chk_idle("after_b");

        // Size header with empty FIFO
        size_cfg   = 9'h04F;
        size_valid = 1'b1;
        exp_q.push_back(32'h0642_004F);
        tick();
        size_valid = 1'b0;
        drain(20, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        chk_idle("after_size");

        // Fill to full: automatic batch, no output-count header
        for (int i = 0; i < 8; i++) push_pair(32'h2, 32'(i + 16));
        chk("full_ready", {31'b0, op_ready}, 32'd0);
        exp_q.push_back(32'h0640_0008);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'h2);
            exp_q.push_back(32'(i + 16));
        end
        drain(60, 1'b0);
        chk_idle("after_full");

        // Backpressure: ready toggles every cycle
        for (int i = 0; i < 3; i++) push_pair(32'h10 + 32'(i), 32'hC0 + 32'(i));
        exp_q.push_back(32'h0640_0003);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h10 + 32'(i));
            exp_q.push_back(32'hC0 + 32'(i));
        end
        do_flush();
        drain(60, 1'b1);
        tick();
        chk_idle("after_toggle");

        // Size strobe and pushes mid-batch: held until the batch completes
        push_pair(32'h1, 32'hD0);
        push_pair(32'h2, 32'hD1);
        push_pair(32'h5, 32'hD2);
        exp_q.push_back(32'h0640_0003);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'hD0);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'hD1);
        exp_q.push_back(32'h5);
        exp_q.push_back(32'hD2);
        exp_q.push_back(32'h0642_01AB);
        do_flush();
        tick();
        size_cfg   = 9'h1AB;
        size_valid = 1'b1;
        tick();
        size_valid = 1'b0;
        push_pair(32'h3, 32'hE0);
        push_pair(32'h4, 32'hE1);
        drain(40, 1'b0);
        chk_idle("after_mid");

        // Second batch holds the two late pairs; clear while mid-pair
        exp_q.push_back(32'h0641_0001);
        exp_q.push_back(32'h0640_0002);
        exp_q.push_back(32'h3);
        do_flush();
        for (int i = 0; i < 3; i++) tick();
        chk("mid_pair_word", stream_word, 32'hE0);
        #2;
        clear = 1'b1;
        #1;
        chk_idle("async_clear");
        chk("clear_word", stream_word, 32'd0);
        chk("clear_left", exp_q.size(), 32'd0);
        exp_q.delete();
        held_v = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        // FIFO must be empty after clear, so flush does nothing
        flush = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b0;
        chk_idle("post_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_stream_encoder.md
Name: cmd_stream_encoder

Overview:
Host-side transmitter for the 32-bit command word stream consumed by data_interface. It buffers (operation, data) pairs in a small FIFO and frames them into batches on a single output bus. Each batch is emitted as: optional size header, optional expected-output header, count header, then op/data word pairs. Its stream output drives data_interface's data_in and enable directly.

Parameters:
DEPTH, 8, pair FIFO depth; power of 2, at most 256; also the maximum batch length.
AW, 3, log2(DEPTH); FIFO pointer width.

Ports:
clk  in  1  global clock
clear  in  1  asynchronous active-high reset
op_word  in  32  operation word; op_word[3:0] is the op type (3 = produces one output)
op_data  in  32  data word paired with op_word
op_valid  in  1  push request for {op_word, op_data}
op_ready  out  1  FIFO not full; a push occurs when op_valid && op_ready
flush  in  1  request to emit all buffered pairs as one batch
size_cfg  in  9  new size code
size_valid  in  1  single-cycle strobe that latches size_cfg as a pending size header
stream_word  out  32  word to the data interface
stream_valid  out  1  word valid; drives the interface enable
stream_ready  in  1  a word transfers when stream_valid && stream_ready
busy  out  1  high from batch start until the last data word transfers

Behaviour:
- Reset (asynchronous, clear=1): FIFO empty, ycnt=0, size_pend=0, state IDLE. Outputs: stream_word=0, stream_valid=0, busy=0, op_ready=1.
- Header formats:
  - COUNT header: {4'h0, 8'h64, 4'h0, n[15:0]}.
  - OUTCNT header: {4'h0, 8'h64, 4'h1, y[15:0]}.
  - SIZE header: {4'h0, 8'h64, 4'h2, 7'b0, size[8:0]}.
- FIFO: DEPTH entries of 65 bits {is_y, op_word, op_data}, where is_y = (op_word[3:0]==3).
  - fcount is AW+1 bits. ycnt is AW+1 bits and counts is_y entries currently held.
  - A simultaneous push and pop is allowed when the FIFO is full; it updates both counts correctly.
  - A push when full is ignored.
  - op_ready = !full, combinational from fcount.
- size_valid latches size_cfg into size_reg and sets size_pend, in any state. A later strobe overwrites size_reg.
- State machine (registered outputs; stream_word/stream_valid change only on a transfer or a state entry):
  - IDLE:
    - size_pend=1 -> SIZE. Size has priority over a batch.
    - else if (flush || full) && fcount!=0 -> snapshot n=fcount, y=ycnt, set busy; go to OCNT if y!=0, else COUNT.
    - flush with an empty FIFO is a no-op. flush is level-sampled only in IDLE.
  - SIZE: present the SIZE header. On transfer clear size_pend (unless a new strobe arrives in the same cycle) -> IDLE.
  - OCNT: present the OUTCNT header -> COUNT on transfer.
  - COUNT: present the COUNT header -> OPW on transfer. Load remaining = n.
  - OPW: present the head op_word -> DATW on transfer.
  - DATW: present the head op_data. On transfer: pop, remaining-1. If remaining becomes 0 -> IDLE and busy=0, else -> OPW.
- Pushes during a batch are accepted, but only the n snapshot entries are emitted. Later entries wait for the next batch.
- stream_valid stays high while stream_ready is low; stream_word must stay stable (no retraction).
- A size_valid strobe mid-batch is held and emitted in IDLE after the batch. It is never inserted between pairs, because the receiver accepts headers only between batches.
- Back-to-back transfers sustain 1 word/cycle. Batch overhead is 1–3 header words.
- Asserting clear mid-batch aborts immediately. There is no partial-batch recovery; the receiver must also be cleared.

Decomposition:
- Shared package holds:
  - the header tag constant 8'h64;
  - subtype constants HDR_COUNT=0, HDR_OUTCNT=1, HDR_SIZE=2;
  - op type constant OP_Y=3;
  - state encoding localparams.
- Sub-module pair_fifo (parameterised DEPTH, 65-bit width, async clear) provides full, empty and fcount. The ycnt tracking lives in the parent.

Test Plan:
- Reset then idle: no stimulus -> stream_valid=0, op_ready=1, busy=0 for 20 cycles.
- Push 2 pairs (op 32'h1, data 32'hA; op 32'h3, data 32'hB), flush, stream_ready=1 -> words 0x0641_0001, 0x0640_0002, 1, A, 3, B; busy drops after B.
- size_valid with size_cfg=9'h04F while idle, FIFO empty -> single word 0x0642_004F, then stream_valid=0.
- Fill 8 pairs with op type 2, no flush -> auto batch: 0x0640_0008 plus 16 words, no OUTCNT header.
- stream_ready toggled 1/0 each cycle during a 3-pair batch -> word sequence unchanged, each word held while ready is low, no duplicates.
- size strobe and 2 extra pushes mid-batch -> current batch is completed, then the SIZE header, then a new batch with count 2; clear asserted mid-pair -> all outputs return to reset values asynchronously.
